io_responder: RTL and testbench
===============================

# io_responder

Memory-mapped I/O responder on the far side of the CPU's port bus: it takes OUT writes (port address on `base`, value on `data`, one-cycle `flag` strobe) and drives the 16-bit `in` word that the CPU samples on IN. It holds a transmit FIFO with a valid/ready drain, a receive holding register with overrun detection, a GPIO output latch, a synchronised GPIO input, and a status word. All port addresses are full 16-bit matches.

## Interface
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, 2..16.
- `GPIO_W`, 16: GPIO width; 1..16, zero-extended on reads.

Ports:
- `clk`  in  1  single clock; everything is sampled on posedge.
- `reset`  in  1  synchronous, active-high.
- `base`  in  16  port address from the CPU, i.e. bx.
- `data`  in  16  write data from the CPU, i.e. dx.
- `flag`  in  1  write strobe, one cycle per OUT.
- `in`  out  16  read data to the CPU; combinational decode of `base` and registered state.
- `tx_data`  out  16  FIFO head.
- `tx_valid`  out  1  FIFO not empty.
- `tx_ready`  in  1  sink accepts head.
- `rx_strobe`  in  1  one-cycle arrival of `rx_word`.
- `rx_word`  in  16  incoming word.
- `gpio_out`  out  GPIO_W  output latch.
- `gpio_in`  in  GPIO_W  asynchronous inputs.

## Operation
Port map, with `base` value:

- **0x0000 status**
  - Read: {11'b0, rx_overrun, tx_overrun, rx_valid, tx_full, tx_empty}, bits 4..0.
  - Write: W1C. `data[3]` clears tx_overrun; `data[4]` clears rx_overrun. Other bits are ignored.
- **0x0001 TX**
  - Write: push `data`.
  - Read: {12'b0, count}. count is 0..FIFO_DEPTH and is zero-extended.
- **0x0002 GPIO out**
  - Write: `gpio_out` <= `data[GPIO_W-1:0]`.
  - Read: `gpio_out`.
- **0x0003 RX**
  - Read: `rx_data`.
  - Write of any value: acknowledge, which clears rx_valid. `rx_data` is retained.
- **0x0004 GPIO in**
  - Read: the 2-flop-synchronised `gpio_in`.
  - Write: ignored.
- **Any other address:** reads return 0; writes are ignored.
- **Writes** act only in cycles where `flag`=1. **Reads** have no side effects.

TX FIFO:
- Circular buffer with rd_ptr, wr_ptr and count.
- Pop: when `tx_valid`&`tx_ready`.
- Push is accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle.
- A push that is not accepted drops `data` and sets tx_overrun (sticky).
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- `tx_data` is undefined when `tx_valid`=0; the bench ignores it.

RX register:
- `rx_strobe` with rx_valid=0: load `rx_word` and set rx_valid.
- `rx_strobe` with rx_valid=1: keep the old data and set rx_overrun (sticky).
- Ack-write and `rx_strobe` in the same cycle: the ack is applied first, so the new word loads, rx_valid stays 1, and there is no overrun.

Sticky bits:
- A W1C clear and a new overrun event in the same cycle: the event wins and the bit stays 1.

## Timing
Reset:
- Asserting `reset` clears count and both pointers, so `tx_valid`=0.
- It also clears `gpio_out`, rx_valid, `rx_data`, both sticky bits and both sync flops. `in` then reads per this state (status = 0x0001).
- `reset` overrides `flag`, `rx_strobe` and pops in the same cycle.
- Reset mid-burst discards FIFO contents.

Latency:
- Writes and strobes take effect at the next edge. A read of the same port in the cycle after a write returns the new value.
- `in` reflects `base` combinationally within the same cycle, with zero wait states.
- `gpio_in` to a readable value: 2 cycles.
- Push to `tx_valid`: 1 cycle, with no fall-through.
- Throughput: one push and one pop per cycle.

## Test plan
- Reset, then read 0x0000 -> 0x0001; `tx_valid`=0, `gpio_out`=0.
- Write 0x0002 = 0xA5A5 -> `gpio_out`=0xA5A5 next cycle; read 0x0002 = 0xA5A5.
- With `tx_ready`=0, push 0x11..0x15 (5 writes, FIFO_DEPTH=4):
  - count=4 and status=0x000A.
  - Raise `tx_ready` -> pops 0x11,0x12,0x13,0x14 on consecutive cycles; 0x15 was dropped.
  - W1C 0x0008 clears bit 3.
- With the FIFO full, push and pop in the same cycle -> accepted, count stays 4, no overrun.
- `rx_strobe` with 0x1234, then with 0x5678:
  - Read 0x0003 = 0x1234; status has bits 2 and 4 set.
  - Ack plus a strobe of 0x9ABC in the same cycle -> rx_valid=1, `rx_data`=0x9ABC.
- Drive `gpio_in`=0x00F0 -> read 0x0004 = 0 for 2 cycles, then 0x00F0. Read 0x7777 -> 0; a write there changes nothing.

Source files
------------

// File: rtl/io_responder.sv
// -----------------------------------------------------------------------------
// io_responder
//
// Memory-mapped I/O responder on the far side of the CPU port bus. OUT writes
// arrive as an address on base, a value on data and a one-cycle flag strobe.
// The CPU samples the combinational in word on IN. Internally there is a TX
// FIFO with a valid/ready drain, an RX holding register with overrun
// detection, a GPIO output latch, a two-flop GPIO input synchroniser and a
// status word. All port addresses are full 16-bit matches.
//
// Port map (base):
//   0x0000 status  R: {11'b0, rxOverrun, txOverrun, rxValid, txFull, txEmpty}
//                  W: write-one-to-clear, data[3] txOverrun, data[4] rxOverrun
//   0x0001 TX      R: FIFO occupancy, zero-extended   W: push data
//   0x0002 GPIO    R: gpio_out, zero-extended         W: load gpio_out
//   0x0003 RX      R: held rx word                    W: acknowledge (clear valid)
//   0x0004 GPIN    R: synchronised gpio_in            W: ignored
//   other          R: 0                               W: ignored
//
// Ports:
//   clk        in   1       single clock, rising edge
//   reset      in   1       synchronous, active-high
//   base       in   16      port address from the CPU
//   data       in   16      write data from the CPU
//   flag       in   1       write strobe, one cycle per OUT
//   in         out  16      read data to the CPU (combinational on base)
//   tx_data    out  16      FIFO head, meaningful only while tx_valid
//   tx_valid   out  1       FIFO not empty
//   tx_ready   in   1       sink accepts the head this cycle
//   rx_strobe  in   1       one-cycle arrival of rx_word
//   rx_word    in   16      incoming word
//   gpio_out   out  GPIO_W  output latch
//   gpio_in    in   GPIO_W  asynchronous inputs
// -----------------------------------------------------------------------------
module io_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int GPIO_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       base,
  input  logic [15:0]       data,
  input  logic              flag,
  output logic [15:0]       in,
  output logic [15:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              rx_strobe,
  input  logic [15:0]       rx_word,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [15:0] ADDR_STATUS = 16'h0000;
  localparam logic [15:0] ADDR_TX     = 16'h0001;
  localparam logic [15:0] ADDR_GPOUT  = 16'h0002;
  localparam logic [15:0] ADDR_RX     = 16'h0003;
  localparam logic [15:0] ADDR_GPIN   = 16'h0004;

  // Write decode
  logic wrStatus;
  logic wrTx;
  logic wrGpOut;
  logic wrRxAck;

  // TX FIFO state
  logic [15:0]      txMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] txRdPtr_q, txRdPtr_d;
  logic [PTR_W-1:0] txWrPtr_q, txWrPtr_d;
  logic [CNT_W-1:0] txCount_q, txCount_d;
  logic             txEmpty;
  logic             txFull;
  logic             txPop;
  logic             txPushOk;
  logic             txDrop;

  // Sticky overrun flags
  logic txOverrun_q, txOverrun_d;
  logic rxOverrun_q, rxOverrun_d;

  // RX holding register
  logic        rxValid_q, rxValid_d;
  logic [15:0] rxData_q,  rxData_d;
  logic        rxValidAfterAck;
  logic        rxLoad;
  logic        rxDrop;

  // GPIO
  logic [GPIO_W-1:0] gpioOut_q,   gpioOut_d;
  logic [GPIO_W-1:0] gpioSync1_q;
  logic [GPIO_W-1:0] gpioSync2_q;

  // Writes only act on the flag strobe and need an exact address match.
  always_comb begin
    wrStatus = flag && (base == ADDR_STATUS);
    wrTx     = flag && (base == ADDR_TX);
    wrGpOut  = flag && (base == ADDR_GPOUT);
    wrRxAck  = flag && (base == ADDR_RX);
  end

  // FIFO handshake terms. A push into a full FIFO still succeeds when the
  // head leaves in the same cycle, which keeps a full FIFO streaming at one
  // word per cycle.
  always_comb begin
    txEmpty  = (txCount_q == '0);
    txFull   = (txCount_q == DEPTH_C);
    txPop    = !txEmpty && tx_ready;
    txPushOk = wrTx && (!txFull || txPop);
    txDrop   = wrTx && !txPushOk;
  end

  // FIFO pointer and occupancy next-state. Pointers are PTR_W bits wide so
  // they wrap modulo the (power-of-two) depth without extra logic.
  always_comb begin
    txRdPtr_d = txRdPtr_q;
    txWrPtr_d = txWrPtr_q;
    txCount_d = txCount_q;
    if (txPop) begin
      txRdPtr_d = txRdPtr_q + PTR_W'(1);
    end
    if (txPushOk) begin
      txWrPtr_d = txWrPtr_q + PTR_W'(1);
    end
    case ({txPushOk, txPop})
      2'b10:   txCount_d = txCount_q + CNT_W'(1);
      2'b01:   txCount_d = txCount_q - CNT_W'(1);
      default: txCount_d = txCount_q;
    endcase
  end

  // FIFO storage has no reset; the pointers alone define which entries are
  // live, so clearing them on reset discards any contents.
  always_ff @(posedge clk) begin
    if (!reset && txPushOk) begin
      txMem_q[txWrPtr_q] <= data;
    end
  end

  // RX register. An acknowledge in the same cycle as a strobe is applied
  // first, so the incoming word sees an empty register and loads cleanly.
  always_comb begin
    rxValidAfterAck = rxValid_q && !wrRxAck;
    rxLoad          = rx_strobe && !rxValidAfterAck;
    rxDrop          = rx_strobe && rxValidAfterAck;

    rxValid_d = rxValidAfterAck;
    rxData_d  = rxData_q;
    if (rxLoad) begin
      rxValid_d = 1'b1;
      rxData_d  = rx_word;
    end
  end

  // Sticky flags: the W1C clear is applied first, then a new overrun event
  // in the same cycle sets the bit again, so the event always wins.
  always_comb begin
    txOverrun_d = txOverrun_q;
    rxOverrun_d = rxOverrun_q;
    if (wrStatus && data[3]) begin
      txOverrun_d = 1'b0;
    end
    if (wrStatus && data[4]) begin
      rxOverrun_d = 1'b0;
    end
    if (txDrop) begin
      txOverrun_d = 1'b1;
    end
    if (rxDrop) begin
      rxOverrun_d = 1'b1;
    end
  end

  // GPIO output latch next-state.
  always_comb begin
    gpioOut_d = gpioOut_q;
    if (wrGpOut) begin
      gpioOut_d = data[GPIO_W-1:0];
    end
  end

  // All control state, with reset taking priority over every write, strobe
  // and pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      txRdPtr_q   <= '0;
      txWrPtr_q   <= '0;
      txCount_q   <= '0;
      txOverrun_q <= 1'b0;
      rxOverrun_q <= 1'b0;
      rxValid_q   <= 1'b0;
      rxData_q    <= '0;
      gpioOut_q   <= '0;
      gpioSync1_q <= '0;
      gpioSync2_q <= '0;
    end else begin
      txRdPtr_q   <= txRdPtr_d;
      txWrPtr_q   <= txWrPtr_d;
      txCount_q   <= txCount_d;
      txOverrun_q <= txOverrun_d;
      rxOverrun_q <= rxOverrun_d;
      rxValid_q   <= rxValid_d;
      rxData_q    <= rxData_d;
      gpioOut_q   <= gpioOut_d;
      gpioSync1_q <= gpio_in;
      gpioSync2_q <= gpioSync1_q;
    end
  end

  // Read mux: purely combinational on base so the CPU sees zero wait states.
  always_comb begin
    in = '0;
    case (base)
      ADDR_STATUS: in = {11'b0, rxOverrun_q, txOverrun_q, rxValid_q, txFull, txEmpty};
      ADDR_TX:     in = 16'(txCount_q);
      ADDR_GPOUT:  in = 16'(gpioOut_q);
      ADDR_RX:     in = rxData_q;
      ADDR_GPIN:   in = 16'(gpioSync2_q);
      default:     in = '0;
    endcase
  end

  // Sink-side outputs.
  always_comb begin
    tx_valid = !txEmpty;
    tx_data  = txMem_q[txRdPtr_q];
    gpio_out = gpioOut_q;
  end

endmodule

// File: tb/tb_io_responder.sv
// -----------------------------------------------------------------------------
// tb_io_responder
//
// Drives io_responder through the documented scenarios and then a randomised
// run, comparing every cycle against a queue-based reference of the port map.
// -----------------------------------------------------------------------------
module tb_io_responder;

  localparam int FIFO_DEPTH = 4;
  localparam int GPIO_W     = 16;

  logic        clk;
  logic        tbReset;
  logic [15:0] tbBase;
  logic [15:0] tbData;
  logic        tbFlag;
  logic [15:0] dutIn;
  logic [15:0] dutTxData;
  logic        dutTxValid;
  logic        tbTxReady;
  logic        tbRxStrobe;
  logic [15:0] tbRxWord;
  logic [15:0] dutGpioOut;
  logic [15:0] tbGpioIn;

  int vectors;
  int miscompares;

  // Reference model state
  logic [15:0] mTxQ[$];
  bit          mTxOv;
  bit          mRxOv;
  bit          mRxValid;
  logic [15:0] mRxData;
  logic [15:0] mGpio;
  logic [15:0] mSync1;
  logic [15:0] mSync2;

  io_responder #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .GPIO_W    (GPIO_W)
  ) dut (
    .clk      (clk),
    .reset    (tbReset),
    .base     (tbBase),
    .data     (tbData),
    .flag     (tbFlag),
    .in       (dutIn),
    .tx_data  (dutTxData),
    .tx_valid (dutTxValid),
    .tx_ready (tbTxReady),
    .rx_strobe(tbRxStrobe),
    .rx_word  (tbRxWord),
    .gpio_out (dutGpioOut),
    .gpio_in  (tbGpioIn)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on a difference counts and reports it.
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // What the CPU should read at a given address, from the model.
  function automatic logic [15:0] expRead(input logic [15:0] addr);
    logic [15:0] r;
    r = 16'h0000;
    case (addr)
      16'h0000: r = {11'b0, mRxOv, mTxOv, mRxValid,
                     (mTxQ.size() == FIFO_DEPTH), (mTxQ.size() == 0)};
      16'h0001: r = 16'(mTxQ.size());
      16'h0002: r = mGpio;
      16'h0003: r = mRxData;
      16'h0004: r = mSync2;
      default:  r = 16'h0000;
    endcase
    return r;
  endfunction

  // Advance the model across one clock edge using the current inputs.
  task automatic modelEdge();
    bit          popNow;
    bit          wasFull;
    bit          dropped;
    logic [15:0] gone;
    if (tbReset) begin
      mTxQ.delete();
      mTxOv    = 0;
      mRxOv    = 0;
      mRxValid = 0;
      mRxData  = 16'h0000;
      mGpio    = 16'h0000;
      mSync1   = 16'h0000;
      mSync2   = 16'h0000;
    end else begin
      popNow  = (mTxQ.size() > 0) && tbTxReady;
      wasFull = (mTxQ.size() == FIFO_DEPTH);
      dropped = 0;
      if (popNow) gone = mTxQ.pop_front();
      if (tbFlag && tbBase == 16'h0001) begin
        if (!wasFull || popNow) mTxQ.push_back(tbData);
        else dropped = 1;
      end
      if (tbFlag && tbBase == 16'h0000 && tbData[3]) mTxOv = 0;
      if (tbFlag && tbBase == 16'h0000 && tbData[4]) mRxOv = 0;
      if (dropped) mTxOv = 1;
      if (tbFlag && tbBase == 16'h0003) mRxValid = 0;
      if (tbRxStrobe) begin
        if (mRxValid) mRxOv = 1;
        else begin
          mRxData  = tbRxWord;
          mRxValid = 1;
        end
      end
      if (tbFlag && tbBase == 16'h0002) mGpio = tbData;
      mSync2 = mSync1;
      mSync1 = tbGpioIn;
    end
  endtask

  // Check all visible outputs against the model, then take one clock edge.
  // Entered and left 1 time unit after a rising edge.
  task automatic applyStimulus();
    #1;
    checkOutput("in", dutIn, expRead(tbBase));
    checkOutput("tx_valid", 16'(dutTxValid), 16'(mTxQ.size() > 0));
    if (mTxQ.size() > 0) checkOutput("tx_data", dutTxData, mTxQ[0]);
    checkOutput("gpio_out", dutGpioOut, mGpio);
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    tbReset     = 1'b1;
    tbBase      = 16'h0000;
    tbData      = 16'h0000;
    tbFlag      = 1'b0;
    tbTxReady   = 1'b0;
    tbRxStrobe  = 1'b0;
    tbRxWord    = 16'h0000;
    tbGpioIn    = 16'h0000;
    mTxQ.delete();
    mTxOv = 0; mRxOv = 0; mRxValid = 0;
    mRxData = 16'h0000; mGpio = 16'h0000; mSync1 = 16'h0000; mSync2 = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    tbReset = 1'b0;

    // Reset state
    applyStimulus();
    checkOutput("reset_status", dutIn, 16'h0001);
    checkOutput("reset_tx_valid", 16'(dutTxValid), 16'h0000);
    checkOutput("reset_gpio_out", dutGpioOut, 16'h0000);

    // GPIO out write, read back the next cycle
    tbBase = 16'h0002; tbData = 16'hA5A5; tbFlag = 1'b1;
    applyStimulus();
    tbFlag = 1'b0;
    checkOutput("gpio_out_write", dutGpioOut, 16'hA5A5);
    checkOutput("gpio_out_read", dutIn, 16'hA5A5);

    // Five pushes into a depth-4 FIFO with the sink stalled
    tbTxReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tbBase = 16'h0001; tbData = 16'h0011 + 16'(i); tbFlag = 1'b1;
      applyStimulus();
    end
    tbFlag = 1'b0;
    checkOutput("fifo_count_full", dutIn, 16'h0004);
    tbBase = 16'h0000;
    #1;
    checkOutput("status_full_overrun", dutIn, 16'h000A);

    // Drain: heads 0x11..0x14 on consecutive cycles, 0x15 was dropped
    tbTxReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_head", dutTxData, 16'h0011 + 16'(i));
      applyStimulus();
    end
    tbTxReady = 1'b0;
    checkOutput("drained_tx_valid", 16'(dutTxValid), 16'h0000);

    // W1C of the TX overrun bit
    tbBase = 16'h0000; tbData = 16'h0008; tbFlag = 1'b1;
    applyStimulus();
    tbFlag = 1'b0;
    checkOutput("w1c_tx_overrun", dutIn, 16'h0001);

    // Full FIFO with simultaneous push and pop: accepted, no overrun
    for (int i = 0; i < 4; i++) begin
      tbBase = 16'h0001; tbData = 16'h0021 + 16'(i); tbFlag = 1'b1;
      applyStimulus();
    end
    tbTxReady = 1'b1; tbData = 16'h0025;
    applyStimulus();
    tbFlag = 1'b0; tbTxReady = 1'b0;
    checkOutput("push_pop_count", dutIn, 16'h0004);
    tbBase = 16'h0000;
    #1;
    checkOutput("push_pop_status", dutIn, 16'h0002);
    tbTxReady = 1'b1;
    repeat (4) applyStimulus();
    tbTxReady = 1'b0;

    // RX: two strobes, second one overruns
    tbRxStrobe = 1'b1; tbRxWord = 16'h1234;
    applyStimulus();
    tbRxWord = 16'h5678;
    applyStimulus();
    tbRxStrobe = 1'b0;
    tbBase = 16'h0003;
    #1;
    checkOutput("rx_data_kept", dutIn, 16'h1234);
    tbBase = 16'h0000;
    #1;
    checkOutput("rx_overrun_status", dutIn, 16'h0015);

    // Ack plus strobe in the same cycle: new word loads, no extra overrun
    tbBase = 16'h0003; tbData = 16'h0000; tbFlag = 1'b1;
    tbRxStrobe = 1'b1; tbRxWord = 16'h9ABC;
    applyStimulus();
    tbFlag = 1'b0; tbRxStrobe = 1'b0;
    checkOutput("ack_strobe_data", dutIn, 16'h9ABC);
    tbBase = 16'h0000;
    #1;
    checkOutput("ack_strobe_status", dutIn, 16'h0015);
    tbData = 16'h0010; tbFlag = 1'b1;
    applyStimulus();
    tbFlag = 1'b0;
    checkOutput("w1c_rx_overrun", dutIn, 16'h0005);

    // GPIO input synchroniser latency
    tbBase = 16'h0004; tbGpioIn = 16'h00F0;
    #1;
    checkOutput("gpin_cycle0", dutIn, 16'h0000);
    applyStimulus();
    checkOutput("gpin_cycle1", dutIn, 16'h0000);
    applyStimulus();
    checkOutput("gpin_cycle2", dutIn, 16'h00F0);

    // Unmapped address: reads zero, writes change nothing
    tbBase = 16'h7777;
    #1;
    checkOutput("unmapped_read", dutIn, 16'h0000);
    tbData = 16'hFFFF; tbFlag = 1'b1;
    applyStimulus();
    tbFlag = 1'b0;
    tbBase = 16'h0002;
    #1;
    checkOutput("unmapped_write_gpio", dutIn, 16'hA5A5);
    applyStimulus();

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 7))
        0, 1:    tbBase = 16'h0001;
        2:       tbBase = 16'h0000;
        3:       tbBase = 16'h0002;
        4:       tbBase = 16'h0003;
        5:       tbBase = 16'h0004;
        6:       tbBase = 16'h7777;
        default: tbBase = 16'($urandom);
      endcase
      tbData     = 16'($urandom);
      tbFlag     = ($urandom_range(0, 1) == 1);
      tbTxReady  = ($urandom_range(0, 2) != 0);
      tbRxStrobe = ($urandom_range(0, 3) == 0);
      tbRxWord   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) tbGpioIn = 16'($urandom);
      tbReset    = ($urandom_range(0, 63) == 0);
      applyStimulus();
    end
    tbReset = 1'b0; tbFlag = 1'b0; tbRxStrobe = 1'b0;

    // Reset mid-burst discards FIFO contents and beats a same-cycle push
    tbTxReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tbBase = 16'h0001; tbData = 16'h0040 + 16'(i); tbFlag = 1'b1;
      applyStimulus();
    end
    tbReset = 1'b1; tbRxStrobe = 1'b1; tbRxWord = 16'hBEEF;
    applyStimulus();
    tbReset = 1'b0; tbFlag = 1'b0; tbRxStrobe = 1'b0;
    checkOutput("midburst_tx_valid", 16'(dutTxValid), 16'h0000);
    tbBase = 16'h0000;
    #1;
    checkOutput("midburst_status", dutIn, 16'h0001);
    applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
